// File: rtl/ex_stage_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_stage_mem_reg
//  Brief    : Execute stage. Forwards operands, runs the ALU, resolves beq,
//             and owns the EX/MEM pipeline register plus the branch shadow.
//             All state is captured on the falling edge of clk.
//  Revision : 1.0  initial release
// ============================================================================
module ex_stage_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_ex_valid,
  input  logic [DATA_W-1:0] nextpc,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] sgn_ext_imm,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic              branch,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [1:0]        alu_op,
  input  logic              fwd_mem_wr,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_wr,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              ex_mem_valid,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic [REG_AW-1:0] ex_mem_dest,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_to_reg,
  output logic              ex_mem_mem_write,
  output logic              ex_mem_mem_read,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              illegal_funct
);

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_rt;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              bad_funct;
  logic [DATA_W-1:0] diff;
  logic              take;
  logic [DATA_W-1:0] target;
  logic [REG_AW-1:0] dest;
  logic [5:0]        funct;
  logic              shadow;

  assign funct = sgn_ext_imm[5:0];

  // Operand A bypass: youngest producer (MEM) wins over WB; r0 is never bypassed.
  always_comb begin
    op_a = rd_data1;
    if (fwd_mem_wr && (fwd_mem_rd == rs_addr) && (rs_addr != '0))
      op_a = fwd_mem_data;
    else if (fwd_wb_wr && (fwd_wb_rd == rs_addr) && (rs_addr != '0))
      op_a = fwd_wb_data;
  end

  // Operand rt bypass: same priority; this value also becomes the store data.
  always_comb begin
    op_rt = rd_data2;
    if (fwd_mem_wr && (fwd_mem_rd == rt_addr) && (rt_addr != '0))
      op_rt = fwd_mem_data;
    else if (fwd_wb_wr && (fwd_wb_rd == rt_addr) && (rt_addr != '0))
      op_rt = fwd_wb_data;
  end

  assign op_b = alu_src ? sgn_ext_imm : op_rt;

  // ALU: alu_op selects a fixed operation or defers to the funct field.
  always_comb begin
    alu_res   = '0;
    bad_funct = 1'b0;
    case (alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_RTYPE: begin
        case (funct)
          FN_ADD:  alu_res = op_a + op_b;
          FN_SUB:  alu_res = op_a - op_b;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default: bad_funct = 1'b1;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // beq resolves on a zero difference; a slot inside the branch shadow never redirects.
  assign diff   = op_a - op_b;
  assign take   = id_ex_valid && branch && (diff == '0) && !shadow;
  assign target = nextpc + (sgn_ext_imm << 2);
  assign dest   = reg_dst ? rd_addr : rt_addr;

  // EX/MEM capture: reset > flush > stall > shadow bubble > normal.
  always_ff @(negedge clk) begin
    if (reset) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_dest       <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      branch_taken      <= 1'b0;
      branch_target     <= '0;
      illegal_funct     <= 1'b0;
      shadow            <= 1'b0;
    end else if (flush_in) begin
      // A flushed slot is itself the bubble, so any pending squash is consumed.
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      branch_taken      <= 1'b0;
      illegal_funct     <= 1'b0;
      shadow            <= 1'b0;
    end else if (stall_in) begin
      // Hold everything except the redirect pulse, which must not repeat.
      branch_taken <= 1'b0;
    end else begin
      ex_mem_alu_result <= alu_res;
      ex_mem_store_data <= op_rt;
      ex_mem_dest       <= dest;
      branch_target     <= target;
      if (shadow || !id_ex_valid) begin
        ex_mem_valid      <= 1'b0;
        ex_mem_reg_write  <= 1'b0;
        ex_mem_mem_to_reg <= 1'b0;
        ex_mem_mem_write  <= 1'b0;
        ex_mem_mem_read   <= 1'b0;
        branch_taken      <= 1'b0;
        illegal_funct     <= 1'b0;
        shadow            <= 1'b0;
      end else begin
        ex_mem_valid      <= 1'b1;
        ex_mem_reg_write  <= reg_write && !bad_funct;
        ex_mem_mem_to_reg <= mem_to_reg;
        ex_mem_mem_write  <= mem_write;
        ex_mem_mem_read   <= mem_read;
        branch_taken      <= take;
        illegal_funct     <= bad_funct;
        shadow            <= take;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_stage_mem_reg
//  Brief    : Self-checking bench for ex_stage_mem_reg: directed vector table
//             plus hand sequences for branch shadow, stall, flush and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage_mem_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ex_valid;
  logic [31:0] nextpc, rd_data1, rd_data2, sgn_ext_imm;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, reg_dst;
  logic [1:0]  alu_op;
  logic        fwd_mem_wr, fwd_wb_wr;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        stall_in, flush_in;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_dest;
  logic        ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_write, ex_mem_mem_read;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal_funct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage_mem_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .nextpc(nextpc),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .sgn_ext_imm(sgn_ext_imm),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .mem_read(mem_read), .branch(branch), .alu_src(alu_src), .reg_dst(reg_dst),
    .alu_op(alu_op), .fwd_mem_wr(fwd_mem_wr), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_wr(fwd_wb_wr), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data), .stall_in(stall_in), .flush_in(flush_in),
    .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_dest(ex_mem_dest),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_to_reg(ex_mem_mem_to_reg),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_mem_read(ex_mem_mem_read),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal_funct(illegal_funct)
  );

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [1:0]  op;
    logic        src, dst, rw;
    logic [2:0]  ctl;          // {mem_to_reg, mem_write, mem_read}
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [31:0] e_res, e_st;
    logic [4:0]  e_dest;
    logic        e_rw, e_ill;
  } vec_t;

  vec_t v[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_ex_valid = 1'b1; nextpc = '0; rd_data1 = '0; rd_data2 = '0; sgn_ext_imm = '0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0;
    reg_write = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    branch = 1'b0; alu_src = 1'b0; reg_dst = 1'b0; alu_op = 2'b00;
    fwd_mem_wr = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_wr = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    stall_in = 1'b0; flush_in = 1'b0;
  endtask

  // beq with equal operands, rt=2 as destination field, reg_write off
  task automatic drive_beq(input logic [31:0] pc, input logic [31:0] imm);
    idle_inputs();
    branch = 1'b1; alu_op = 2'b01; rs_addr = 5'd1; rt_addr = 5'd2;
    rd_data1 = 32'd9; rd_data2 = 32'd9; nextpc = pc; sgn_ext_imm = imm;
  endtask

  // add r3 = r1 + r2 with given operand values
  task automatic drive_add(input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3; reg_dst = 1'b1; reg_write = 1'b1;
    rd_data1 = a; rd_data2 = b;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_mem_valid}, 32'd0);
    chk({tag, "_res"}, ex_mem_alu_result, 32'd0);
    chk({tag, "_st"}, ex_mem_store_data, 32'd0);
    chk({tag, "_dest"}, {27'd0, ex_mem_dest}, 32'd0);
    chk({tag, "_ctl"}, {28'd0, ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_write, ex_mem_mem_read}, 32'd0);
    chk({tag, "_taken"}, {31'd0, branch_taken}, 32'd0);
    chk({tag, "_tgt"}, branch_target, 32'd0);
    chk({tag, "_ill"}, {31'd0, illegal_funct}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    //        rs    rt    rd    d1            d2            imm           op     src   dst   rw    ctl     mw    mrd   mdat          ww    wrd   wdat          e_res         e_st          e_dest e_rw e_ill
    v[0]  = '{5'd5, 5'd0, 5'd3, 32'h00001111, 32'h00000000, 32'h00000000, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 5'd5, 32'h0000AAAA, 1'b1, 5'd5, 32'h0000BBBB, 32'h0000AAAA, 32'h00000000, 5'd3, 1'b1, 1'b0};
    v[1]  = '{5'd5, 5'd0, 5'd3, 32'h00000001, 32'h00000000, 32'h00000000, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 5'd6, 32'h0000AAAA, 1'b1, 5'd5, 32'h0000BBBB, 32'h0000BBBB, 32'h00000000, 5'd3, 1'b1, 1'b0};
    v[2]  = '{5'd0, 5'd4, 5'd3, 32'h00000000, 32'h00001234, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 5'd0, 32'h00000007, 1'b1, 5'd0, 32'h00000009, 32'h00001234, 32'h00001234, 5'd4, 1'b1, 1'b0};
    v[3]  = '{5'd1, 5'd2, 5'd3, 32'h0000000A, 32'h00000003, 32'h00000000, 2'b01, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h00000007, 32'h00000003, 5'd3, 1'b1, 1'b0};
    v[4]  = '{5'd1, 5'd2, 5'd3, 32'h000000F0, 32'h00000077, 32'h0000000F, 2'b11, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h000000FF, 32'h00000077, 5'd2, 1'b1, 1'b0};
    v[5]  = '{5'd1, 5'd2, 5'd3, 32'hFF00FF00, 32'h0FF00FF0, 32'h00000024, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h0F000F00, 32'h0FF00FF0, 5'd3, 1'b1, 1'b0};
    v[6]  = '{5'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h0000002A, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h00000001, 32'h00000001, 5'd3, 1'b1, 1'b0};
    v[7]  = '{5'd1, 5'd2, 5'd3, 32'h00000001, 32'hFFFFFFFF, 32'h0000002A, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0};
    v[8]  = '{5'd1, 5'd2, 5'd3, 32'h00000000, 32'h00000001, 32'h00000022, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 5'd3, 1'b1, 1'b0};
    v[9]  = '{5'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000020, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h00000001, 32'h00000002, 5'd3, 1'b1, 1'b0};
    v[10] = '{5'd1, 5'd2, 5'd3, 32'h00000005, 32'h00000006, 32'h00000021, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h00000000, 32'h00000006, 5'd3, 1'b0, 1'b1};
    v[11] = '{5'd1, 5'd2, 5'd3, 32'h00000005, 32'h0000000A, 32'h00000025, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b0, 5'd0, 32'h00000000, 32'h0000000F, 32'h0000000A, 5'd3, 1'b1, 1'b0};
    v[12] = '{5'd0, 5'd7, 5'd3, 32'h00000000, 32'h00000099, 32'h00000020, 2'b10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h00000000, 1'b1, 5'd7, 32'h00000055, 32'h00000055, 32'h00000055, 5'd3, 1'b1, 1'b0};
    v[13] = '{5'd1, 5'd2, 5'd3, 32'h00000100, 32'h0000DEAD, 32'h00000008, 2'b00, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'd2, 32'h0000BEEF, 1'b0, 5'd0, 32'h00000000, 32'h00000108, 32'h0000BEEF, 5'd2, 1'b0, 1'b0};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Table-driven single-instruction vectors
    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      rs_addr = v[i].rs; rt_addr = v[i].rt; rd_addr = v[i].rd;
      rd_data1 = v[i].d1; rd_data2 = v[i].d2; sgn_ext_imm = v[i].imm;
      alu_op = v[i].op; alu_src = v[i].src; reg_dst = v[i].dst; reg_write = v[i].rw;
      {mem_to_reg, mem_write, mem_read} = v[i].ctl;
      fwd_mem_wr = v[i].mw; fwd_mem_rd = v[i].mrd; fwd_mem_data = v[i].mdat;
      fwd_wb_wr = v[i].ww; fwd_wb_rd = v[i].wrd; fwd_wb_data = v[i].wdat;
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, ex_mem_valid}, 32'd1);
      chk($sformatf("v%0d_res", i), ex_mem_alu_result, v[i].e_res);
      chk($sformatf("v%0d_st", i), ex_mem_store_data, v[i].e_st);
      chk($sformatf("v%0d_dest", i), {27'd0, ex_mem_dest}, {27'd0, v[i].e_dest});
      chk($sformatf("v%0d_rw", i), {31'd0, ex_mem_reg_write}, {31'd0, v[i].e_rw});
      chk($sformatf("v%0d_ill", i), {31'd0, illegal_funct}, {31'd0, v[i].e_ill});
      chk($sformatf("v%0d_ctl", i), {29'd0, ex_mem_mem_to_reg, ex_mem_mem_write, ex_mem_mem_read}, {29'd0, v[i].ctl});
      chk($sformatf("v%0d_taken", i), {31'd0, branch_taken}, 32'd0);
    end

    // Taken beq, then squashed slot (itself a matching beq), then normal capture
    drive_beq(32'h00000100, 32'hFFFFFFFE);
    tick();
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    chk("beq_target", branch_target, 32'h000000F8);
    chk("beq_valid", {31'd0, ex_mem_valid}, 32'd1);
    drive_beq(32'h00000200, 32'h00000001);
    tick();
    chk("shadow_valid", {31'd0, ex_mem_valid}, 32'd0);
    chk("shadow_taken", {31'd0, branch_taken}, 32'd0);
    drive_add(32'd4, 32'd5);
    tick();
    chk("post_shadow_valid", {31'd0, ex_mem_valid}, 32'd1);
    chk("post_shadow_res", ex_mem_alu_result, 32'd9);
    chk("post_shadow_rw", {31'd0, ex_mem_reg_write}, 32'd1);

    // Target wrap
    drive_beq(32'hFFFFFFFC, 32'h00000002);
    tick();
    chk("wrap_taken", {31'd0, branch_taken}, 32'd1);
    chk("wrap_target", branch_target, 32'h00000004);
    drive_add(32'd1, 32'd1);
    tick();
    chk("wrap_shadow_valid", {31'd0, ex_mem_valid}, 32'd0);

    // Stall held three edges after a taken branch
    drive_beq(32'h00000100, 32'hFFFFFFFE);
    tick();
    chk("stall_pre_taken", {31'd0, branch_taken}, 32'd1);
    drive_add(32'd1, 32'd2);
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_taken", k), {31'd0, branch_taken}, 32'd0);
      chk($sformatf("stall%0d_valid", k), {31'd0, ex_mem_valid}, 32'd1);
      chk($sformatf("stall%0d_res", k), ex_mem_alu_result, 32'd0);
      chk($sformatf("stall%0d_dest", k), {27'd0, ex_mem_dest}, 32'd2);
      chk($sformatf("stall%0d_rw", k), {31'd0, ex_mem_reg_write}, 32'd0);
    end
    stall_in = 1'b0;
    tick();
    chk("stall_release_bubble", {31'd0, ex_mem_valid}, 32'd0);
    tick();
    chk("stall_after_valid", {31'd0, ex_mem_valid}, 32'd1);
    chk("stall_after_res", ex_mem_alu_result, 32'd3);

    // Flush together with stall yields a bubble
    drive_add(32'd7, 32'd8);
    {mem_to_reg, mem_write, mem_read} = 3'b111;
    tick();
    chk("pre_flush_ctl", {28'd0, ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_write, ex_mem_mem_read}, 32'hF);
    flush_in = 1'b1; stall_in = 1'b1;
    tick();
    chk("flush_valid", {31'd0, ex_mem_valid}, 32'd0);
    chk("flush_ctl", {28'd0, ex_mem_reg_write, ex_mem_mem_to_reg, ex_mem_mem_write, ex_mem_mem_read}, 32'd0);
    chk("flush_taken", {31'd0, branch_taken}, 32'd0);

    // Reset during the squash window
    drive_beq(32'h00000100, 32'hFFFFFFFE);
    tick();
    chk("rst_pre_taken", {31'd0, branch_taken}, 32'd1);
    drive_add(32'd2, 32'd3);
    reset = 1'b1;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b0;
    tick();
    chk("rst_after_valid", {31'd0, ex_mem_valid}, 32'd1);
    chk("rst_after_res", ex_mem_alu_result, 32'd5);

    // Invalid slot with matching beq never redirects
    drive_beq(32'h00000100, 32'hFFFFFFFE);
    id_ex_valid = 1'b0;
    reg_write = 1'b1;
    tick();
    chk("inv_valid", {31'd0, ex_mem_valid}, 32'd0);
    chk("inv_taken", {31'd0, branch_taken}, 32'd0);
    chk("inv_rw", {31'd0, ex_mem_reg_write}, 32'd0);
    drive_add(32'd10, 32'd20);
    tick();
    chk("inv_next_valid", {31'd0, ex_mem_valid}, 32'd1);
    chk("inv_next_res", ex_mem_alu_result, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
